// File: rtl/lcd_cmd_driver_if.sv
// Bus between the LSU io_lcd output register and the HD44780 command driver.
// The slave modport is the driver's view; master is the LSU/board side.
interface lcd_cmd_driver_if;
  logic [31:0] lcd_word_i;
  logic [7:0]  lcd_data_o;
  logic        lcd_rs_o;
  logic        lcd_rw_o;
  logic        lcd_en_o;
  logic        lcd_on_o;
  logic        busy_o;
  logic        ack_tog_o;

  modport slave (
    input  lcd_word_i,
    output lcd_data_o,
    output lcd_rs_o,
    output lcd_rw_o,
    output lcd_en_o,
    output lcd_on_o,
    output busy_o,
    output ack_tog_o
  );

  modport master (
    output lcd_word_i,
    input  lcd_data_o,
    input  lcd_rs_o,
    input  lcd_rw_o,
    input  lcd_en_o,
    input  lcd_on_o,
    input  busy_o,
    input  ack_tog_o
  );
endinterface

// File: rtl/lcd_cmd_driver.sv
// Turns the level-held io_lcd word into timed HD44780 write cycles and runs the
// fixed power-up init sequence. Every cycle parameter must be >= 1.
module lcd_cmd_driver #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 25,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned EXEC_CYC  = 2000,
  parameter int unsigned CLEAR_CYC = 82000,
  parameter int unsigned INIT_CYC  = 750000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  lcd_cmd_driver_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_INIT_WAIT = 3'd0,
    ST_IDLE      = 3'd1,
    ST_SETUP     = 3'd2,
    ST_PULSE     = 3'd3,
    ST_HOLD      = 3'd4,
    ST_EXEC      = 3'd5
  } state_e;

  localparam logic [19:0] SETUP_LD = 20'(SETUP_CYC - 1);
  localparam logic [19:0] PULSE_LD = 20'(PULSE_CYC - 1);
  localparam logic [19:0] HOLD_LD  = 20'(HOLD_CYC - 1);
  localparam logic [19:0] EXEC_LD  = 20'(EXEC_CYC - 1);
  localparam logic [19:0] CLEAR_LD = 20'(CLEAR_CYC - 1);
  localparam logic [19:0] INIT_LD  = 20'(INIT_CYC - 1);

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = 8'h38;
      2'd1:    cmd = 8'h0C;
      2'd2:    cmd = 8'h01;
      2'd3:    cmd = 8'h06;
      default: cmd = 8'h00;
    endcase
    return cmd;
  endfunction

  // Clear and return-home need the long execution wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && ((data == 8'h01) || (data == 8'h02));
  endfunction

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic        rs_q, rs_d;
  logic        ack_q, ack_d;
  logic        init_q, init_d;
  logic [1:0]  idx_q, idx_d;
  logic        en_q, en_d;
  logic        busy_q, busy_d;
  logic        on_q;
  logic        pend_s;
  logic        cnt_zero_s;
  logic        accept_s;
  logic        unused_word_bits;

  assign pend_s           = (bus.lcd_word_i[30] != ack_q);
  assign cnt_zero_s       = (cnt_q == 20'd0);
  assign unused_word_bits = ^bus.lcd_word_i[29:9];

  // Next-state, counter and capture logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    rs_d     = rs_q;
    ack_d    = ack_q;
    init_d   = init_q;
    idx_d    = idx_q;
    accept_s = 1'b0;

    case (state_q)
      ST_INIT_WAIT: begin
        if (cnt_zero_s) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
          data_d  = init_cmd(2'd0);
          rs_d    = 1'b0;
          idx_d   = 2'd0;
          init_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      ST_IDLE: begin
        if (pend_s) begin
          accept_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_zero_s) begin
          state_d = ST_PULSE;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      ST_PULSE: begin
        if (cnt_zero_s) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_zero_s) begin
          state_d = ST_EXEC;
          cnt_d   = is_slow_cmd(rs_q, data_q) ? CLEAR_LD : EXEC_LD;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      ST_EXEC: begin
        if (!cnt_zero_s) begin
          cnt_d = cnt_q - 20'd1;
        end else if (init_q) begin
          if (idx_q == 2'd3) begin
            state_d = ST_IDLE;
            init_d  = 1'b0;
          end else begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LD;
            idx_d   = idx_q + 2'd1;
            data_d  = init_cmd(idx_q + 2'd1);
            rs_d    = 1'b0;
          end
        end else if (pend_s) begin
          // Back-to-back: the queued request takes the edge busy would fall on.
          accept_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_INIT_WAIT;
        cnt_d   = INIT_LD;
        init_d  = 1'b1;
        idx_d   = 2'd0;
      end
    endcase

    if (accept_s) begin
      state_d = ST_SETUP;
      cnt_d   = SETUP_LD;
      data_d  = bus.lcd_word_i[7:0];
      rs_d    = bus.lcd_word_i[8];
      ack_d   = bus.lcd_word_i[30];
    end else begin
      ack_d = ack_q;
    end

    en_d   = (state_d == ST_PULSE);
    busy_d = (state_d != ST_IDLE);
  end

  // State, counter and registered pin drivers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_INIT_WAIT;
      cnt_q   <= INIT_LD;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      ack_q   <= 1'b0;
      init_q  <= 1'b1;
      idx_q   <= 2'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b1;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      ack_q   <= ack_d;
      init_q  <= init_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      on_q    <= bus.lcd_word_i[31];
    end
  end

  assign bus.lcd_data_o = data_q;
  assign bus.lcd_rs_o   = rs_q;
  assign bus.lcd_rw_o   = 1'b0;
  assign bus.lcd_en_o   = en_q;
  assign bus.lcd_on_o   = on_q;
  assign bus.busy_o     = busy_q;
  assign bus.ack_tog_o  = ack_q;

endmodule

// File: tb/tb_lcd_cmd_driver.sv
// Bench for lcd_cmd_driver: timeline model of transfers checked every cycle,
// plus directed scenarios with hand-computed pulse counts and busy lengths.
module tb_lcd_cmd_driver;
  localparam int S = 2;
  localparam int P = 4;
  localparam int H = 2;
  localparam int E = 10;
  localparam int C = 30;
  localparam int I = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  lcd_cmd_driver_if bus();

  lcd_cmd_driver #(
    .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H),
    .EXEC_CYC(E), .CLEAR_CYC(C), .INIT_CYC(I)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] init_tab [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  // Model: a job starts on an edge (k=0) and occupies len edges; EN is high for k in [S, S+P).
  int         m_k, m_len, m_ncmd;
  logic       m_busy, m_xfer, m_init, m_ack, m_on, m_rs;
  logic [7:0] m_data;

  function automatic int job_len(input logic rs, input logic [7:0] d);
    return S + P + H + (((rs == 1'b0) && (d == 8'h01 || d == 8'h02)) ? C : E);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_step
    logic pend;
    if (!rst_n) begin
      m_on = 1'b0; m_ack = 1'b0; m_data = 8'h00; m_rs = 1'b0;
      m_busy = 1'b1; m_xfer = 1'b0; m_init = 1'b1; m_ncmd = 0;
      m_k = 0; m_len = I;
    end else begin
      pend = (bus.lcd_word_i[30] != m_ack);
      m_on = bus.lcd_word_i[31];
      if (m_busy) m_k = m_k + 1;
      if (m_busy && m_k == m_len) begin
        if (m_init && m_ncmd < 4) begin
          m_data = init_tab[m_ncmd]; m_rs = 1'b0; m_ncmd = m_ncmd + 1;
          m_k = 0; m_len = job_len(m_rs, m_data); m_xfer = 1'b1;
        end else if (m_init) begin
          m_init = 1'b0; m_busy = 1'b0; m_xfer = 1'b0;
        end else if (pend) begin
          m_data = bus.lcd_word_i[7:0]; m_rs = bus.lcd_word_i[8]; m_ack = bus.lcd_word_i[30];
          m_k = 0; m_len = job_len(m_rs, m_data); m_xfer = 1'b1;
        end else begin
          m_busy = 1'b0; m_xfer = 1'b0;
        end
      end else if (!m_busy && pend) begin
        m_data = bus.lcd_word_i[7:0]; m_rs = bus.lcd_word_i[8]; m_ack = bus.lcd_word_i[30];
        m_k = 0; m_len = job_len(m_rs, m_data); m_xfer = 1'b1; m_busy = 1'b1;
      end
    end
  end

  // EN pulse recorder: data/RS at the rising sample, width in cycles, rise cycle.
  int         cyc = 0;
  int         p_cnt = 0;
  logic       en_prev = 1'b0;
  logic [7:0] p_data [64];
  logic       p_rs   [64];
  int         p_w    [64];
  int         p_rise [64];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.lcd_en_o && !en_prev && p_cnt < 64) begin
      p_data[p_cnt] = bus.lcd_data_o;
      p_rs[p_cnt]   = bus.lcd_rs_o;
      p_w[p_cnt]    = 1;
      p_rise[p_cnt] = cyc;
      p_cnt         = p_cnt + 1;
    end else if (bus.lcd_en_o && p_cnt > 0) begin
      p_w[p_cnt-1] = p_w[p_cnt-1] + 1;
    end
    en_prev = bus.lcd_en_o;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      chk("cmp_data", 32'(bus.lcd_data_o), 32'(m_data));
      chk("cmp_rs",   32'(bus.lcd_rs_o),   32'(m_rs));
      chk("cmp_rw",   32'(bus.lcd_rw_o),   32'd0);
      chk("cmp_en",   32'(bus.lcd_en_o),   32'(m_busy && m_xfer && m_k >= S && m_k < S + P));
      chk("cmp_on",   32'(bus.lcd_on_o),   32'(m_on));
      chk("cmp_busy", 32'(bus.busy_o),     32'(m_busy));
      chk("cmp_ack",  32'(bus.ack_tog_o),  32'(m_ack));
    end
  endtask

  // Counts negedge samples with busy high; stops at the first low sample or the budget.
  task automatic measure_busy(input int budget, output int hi);
    hi = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.busy_o) hi++;
      else break;
    end
  endtask

  task automatic check_init(input int p0);
    int hi;
    measure_busy(400, hi);
    chk("init_busy_fall", 32'(hi + 1), 32'd112);
    chk("init_pulses", 32'(p_cnt - p0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("init_data",  32'(p_data[p0+i]), 32'(init_tab[i]));
      chk("init_rs",    32'(p_rs[p0+i]),   32'd0);
      chk("init_width", 32'(p_w[p0+i]),    32'd4);
    end
  endtask

  task automatic run();
    int hi, p0, a;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(bus.lcd_data_o), 32'h00);
    chk("rst_rs",   32'(bus.lcd_rs_o),   32'd0);
    chk("rst_en",   32'(bus.lcd_en_o),   32'd0);
    chk("rst_on",   32'(bus.lcd_on_o),   32'd0);
    chk("rst_busy", 32'(bus.busy_o),     32'd1);
    chk("rst_ack",  32'(bus.ack_tog_o),  32'd0);
    rst_n = 1'b1;
    check_init(p_cnt);

    // Single data write
    p0 = p_cnt; a = cyc + 1;
    bus.lcd_word_i = 32'h4000_0141;
    measure_busy(200, hi);
    chk("wr_busy_len", 32'(hi), 32'd18);
    chk("wr_pulses",   32'(p_cnt - p0), 32'd1);
    chk("wr_data",     32'(p_data[p0]), 32'h41);
    chk("wr_rs",       32'(p_rs[p0]), 32'd1);
    chk("wr_width",    32'(p_w[p0]), 32'd4);
    chk("wr_en_delay", 32'(p_rise[p0] - a), 32'd2);
    chk("wr_ack",      32'(bus.ack_tog_o), 32'd1);

    // Clear command uses the long wait
    p0 = p_cnt;
    bus.lcd_word_i = 32'h0000_0001;
    measure_busy(200, hi);
    chk("clr_busy_len", 32'(hi), 32'd38);
    chk("clr_data",     32'(p_data[p0]), 32'h01);
    chk("clr_ack",      32'(bus.ack_tog_o), 32'd0);

    // Data bits change to 0xFF while EN is high
    p0 = p_cnt;
    bus.lcd_word_i = 32'h4000_0155;
    repeat (3) @(negedge clk);
    bus.lcd_word_i = 32'h4000_01FF;
    @(negedge clk);
    chk("mid_en",   32'(bus.lcd_en_o), 32'd1);
    chk("mid_data", 32'(bus.lcd_data_o), 32'h55);
    measure_busy(200, hi);
    chk("mid_drain", 32'(hi), 32'd14);
    chk("mid_pulse_data", 32'(p_data[p0]), 32'h55);

    // Request queued during a transfer is chained without a busy gap
    p0 = p_cnt;
    bus.lcd_word_i = 32'h0000_0142;
    repeat (5) @(negedge clk);
    bus.lcd_word_i = 32'h4000_0143;
    measure_busy(200, hi);
    chk("q_busy_rest", 32'(hi), 32'd31);
    chk("q_pulses",    32'(p_cnt - p0), 32'd2);
    chk("q_data0",     32'(p_data[p0]), 32'h42);
    chk("q_data1",     32'(p_data[p0+1]), 32'h43);
    chk("q_spacing",   32'(p_rise[p0+1] - p_rise[p0]), 32'd18);
    chk("q_ack",       32'(bus.ack_tog_o), 32'd1);

    // Double toggle inside one transfer sends nothing extra
    p0 = p_cnt;
    bus.lcd_word_i = 32'h0000_0144;
    repeat (3) @(negedge clk);
    bus.lcd_word_i = 32'h4000_0144;
    repeat (3) @(negedge clk);
    bus.lcd_word_i = 32'h0000_0144;
    measure_busy(200, hi);
    chk("dbl_busy_rest", 32'(hi), 32'd12);
    repeat (5) @(negedge clk);
    chk("dbl_pulses", 32'(p_cnt - p0), 32'd1);
    chk("dbl_idle",   32'(bus.busy_o), 32'd0);

    // Display power follows bit 31 with no request
    bus.lcd_word_i = 32'h8000_0144;
    @(negedge clk);
    chk("on_set",  32'(bus.lcd_on_o), 32'd1);
    chk("on_busy", 32'(bus.busy_o), 32'd0);

    // Asynchronous reset while EN is high
    bus.lcd_word_i = 32'hC000_0146;
    repeat (3) @(negedge clk);
    chk("ar_en_before", 32'(bus.lcd_en_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_en_drop", 32'(bus.lcd_en_o), 32'd0);
    chk("ar_busy",    32'(bus.busy_o), 32'd1);
    chk("ar_data",    32'(bus.lcd_data_o), 32'h00);
    chk("ar_ack",     32'(bus.ack_tog_o), 32'd0);
    chk("ar_on",      32'(bus.lcd_on_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_init(p_cnt);

    // The toggle still differing from the reset ack is served after init
    p0 = p_cnt;
    measure_busy(200, hi);
    chk("ar_post_busy", 32'(hi), 32'd18);
    chk("ar_post_data", 32'(p_data[p0]), 32'h46);
    chk("ar_post_ack",  32'(bus.ack_tog_o), 32'd1);
  endtask

  initial begin
    bus.lcd_word_i = 32'h0000_0000;
    #1 rst_n = 1'b0;
    fork
      compare_loop();
    join_none
    run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
